// File: rtl/dma_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_engine_if
// Brief    : Request, status and read/write bus bundle for dma_engine.
// Revision : 1.0
// ============================================================================
interface dma_engine_if;
  // transfer request
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] transfer_size;
  logic [2:0]  burst_size;
  logic [1:0]  data_width;
  logic        src_incr;
  logic        dst_incr;
  // read port
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_err;
  // write port
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  // status
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] cur_src_addr;
  logic [31:0] cur_dst_addr;
  logic [31:0] remaining_bytes;

  modport master (
    input  start, src_addr, dst_addr, transfer_size, burst_size, data_width,
           src_incr, dst_incr,
    output rd_req, rd_addr, rd_size,
    input  rd_ack, rd_data, rd_err,
    output wr_req, wr_addr, wr_size, wr_data,
    input  wr_ack, wr_err,
    output busy, done, error, cur_src_addr, cur_dst_addr, remaining_bytes
  );

  modport slave (
    output start, src_addr, dst_addr, transfer_size, burst_size, data_width,
           src_incr, dst_incr,
    input  rd_req, rd_addr, rd_size,
    output rd_ack, rd_data, rd_err,
    input  wr_req, wr_addr, wr_size, wr_data,
    output wr_ack, wr_err,
    input  busy, done, error, cur_src_addr, cur_dst_addr, remaining_bytes
  );
endinterface
`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_engine
// Brief    : Single-channel burst DMA: read up to 16 beats into a buffer,
//            write them out, repeat until the byte count is exhausted.
//            Optional abort input when DMA_ENGINE_ABORT_EN is defined.
// Revision : 1.0
// ============================================================================
module dma_engine (
  input  logic         clk,
  input  logic         rst,
`ifdef DMA_ENGINE_ABORT_EN
  input  logic         abort,
`endif
  dma_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e      state_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] rem_q;
  logic [1:0]  width_q;
  logic [2:0]  burst_q;
  logic        src_incr_q;
  logic        dst_incr_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic        rd_req_q;
  logic        wr_req_q;
  logic [4:0]  rd_ptr_q;
  logic [4:0]  wr_ptr_q;
  logic [4:0]  blen_q;
  logic [31:0] buf_q [16];

  logic [31:0] bpb;
  logic [31:0] align_mask;
  logic [31:0] data_mask;
  logic        cfg_bad;
  logic [31:0] src_next_d;
  logic [31:0] dst_next_d;
  logic [31:0] rem_next_d;
  logic        rd_last;
  logic        wr_last;
  logic        abort_w;

`ifdef DMA_ENGINE_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign bpb        = 32'd1 << width_q;
  assign align_mask = bpb - 32'd1;
  assign src_next_d = src_q + bpb;
  assign dst_next_d = dst_q + bpb;
  assign rem_next_d = rem_q - bpb;
  assign rd_last    = (rd_ptr_q + 5'd1) == blen_q;
  assign wr_last    = (wr_ptr_q + 5'd1) == blen_q;

  assign cfg_bad = (width_q == 2'b11)
                 || ((rem_q & align_mask) != 32'd0)
                 || ((src_q & align_mask) != 32'd0)
                 || ((dst_q & align_mask) != 32'd0);

  always_comb begin
    data_mask = 32'hFFFF_FFFF;
    case (width_q)
      2'b00:   data_mask = 32'h0000_00FF;
      2'b01:   data_mask = 32'h0000_FFFF;
      default: data_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Beats in the next burst: min(2^burst, 16, beats still to move).
  function automatic logic [4:0] f_blen(input logic [31:0] rem,
                                        input logic [1:0]  w,
                                        input logic [2:0]  b);
    logic [31:0] beats;
    logic [4:0]  cap;
    beats = rem >> w;
    cap   = (b >= 3'd4) ? 5'd16 : (5'd1 << b);
    f_blen = (beats < {27'd0, cap}) ? beats[4:0] : cap;
  endfunction

  assign bus.rd_req          = rd_req_q;
  assign bus.rd_addr         = src_q;
  assign bus.rd_size         = width_q;
  assign bus.wr_req          = wr_req_q;
  assign bus.wr_addr         = dst_q;
  assign bus.wr_size         = width_q;
  assign bus.wr_data         = wr_req_q ? buf_q[wr_ptr_q[3:0]] : 32'd0;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.cur_src_addr    = src_q;
  assign bus.cur_dst_addr    = dst_q;
  assign bus.remaining_bytes = rem_q;

  // Buffer contents need no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (state_q == S_READ && rd_req_q && bus.rd_ack && !bus.rd_err) begin
      buf_q[rd_ptr_q[3:0]] <= bus.rd_data & data_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      rem_q      <= 32'd0;
      width_q    <= 2'd0;
      burst_q    <= 3'd0;
      src_incr_q <= 1'b0;
      dst_incr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_ptr_q   <= 5'd0;
      wr_ptr_q   <= 5'd0;
      blen_q     <= 5'd0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            src_q      <= bus.src_addr;
            dst_q      <= bus.dst_addr;
            rem_q      <= bus.transfer_size;
            width_q    <= bus.data_width;
            burst_q    <= bus.burst_size;
            src_incr_q <= bus.src_incr;
            dst_incr_q <= bus.dst_incr;
            rd_ptr_q   <= 5'd0;
            wr_ptr_q   <= 5'd0;
            busy_q     <= 1'b1;
            state_q    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cfg_bad) begin
            state_q <= S_FAULT;
            error_q <= 1'b1;
          end else if (rem_q == 32'd0) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            blen_q   <= f_blen(rem_q, width_q, burst_q);
            rd_ptr_q <= 5'd0;
            state_q  <= S_READ;
          end
        end

        // First cycle in READ/WRITE is a setup cycle with the request low.
        S_READ: begin
          if (!rd_req_q) begin
            if (abort_w) begin
              state_q <= S_FAULT;
              error_q <= 1'b1;
            end else begin
              rd_req_q <= 1'b1;
            end
          end else if (bus.rd_ack) begin
            if (bus.rd_err) begin
              rd_req_q <= 1'b0;
              state_q  <= S_FAULT;
              error_q  <= 1'b1;
            end else begin
              if (src_incr_q) src_q <= src_next_d;
              rd_ptr_q <= rd_ptr_q + 5'd1;
              if (abort_w) begin
                rd_req_q <= 1'b0;
                state_q  <= S_FAULT;
                error_q  <= 1'b1;
              end else if (rd_last) begin
                rd_req_q <= 1'b0;
                wr_ptr_q <= 5'd0;
                state_q  <= S_WRITE;
              end
            end
          end
        end

        S_WRITE: begin
          if (!wr_req_q) begin
            if (abort_w) begin
              state_q <= S_FAULT;
              error_q <= 1'b1;
            end else begin
              wr_req_q <= 1'b1;
            end
          end else if (bus.wr_ack) begin
            if (bus.wr_err) begin
              wr_req_q <= 1'b0;
              state_q  <= S_FAULT;
              error_q  <= 1'b1;
            end else begin
              if (dst_incr_q) dst_q <= dst_next_d;
              rem_q    <= rem_next_d;
              wr_ptr_q <= wr_ptr_q + 5'd1;
              if (abort_w) begin
                wr_req_q <= 1'b0;
                state_q  <= S_FAULT;
                error_q  <= 1'b1;
              end else if (wr_last) begin
                wr_req_q <= 1'b0;
                if (rem_next_d == 32'd0) begin
                  state_q <= S_FINISH;
                  done_q  <= 1'b1;
                end else begin
                  blen_q   <= f_blen(rem_next_d, width_q, burst_q);
                  rd_ptr_q <= 5'd0;
                  state_q  <= S_READ;
                end
              end
            end
          end
        end

        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_FAULT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_engine
// Brief    : Directed self-checking bench for dma_engine with a one-beat-per-
//            cycle memory responder and transaction logs.
// Revision : 1.0
// ============================================================================
module tb_dma_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_engine_if bus();

`ifdef DMA_ENGINE_ABORT_EN
  logic abort;
`endif

  dma_engine dut (
    .clk   (clk),
    .rst   (rst),
`ifdef DMA_ENGINE_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int rd_cnt, wr_cnt, seq_cnt, overlap, done_cnt, err_cnt, err_read_at;
  logic [31:0] rd_log      [64];
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];
  logic        seq_log     [128];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC3A5_0F96;
  endfunction

  // Memory responder: acks any request seen at the falling edge.
  always @(negedge clk) begin
    bus.rd_ack  = 1'b0;
    bus.rd_err  = 1'b0;
    bus.rd_data = 32'd0;
    bus.wr_ack  = 1'b0;
    bus.wr_err  = 1'b0;
    if (bus.rd_req === 1'b1) begin
      bus.rd_ack  = 1'b1;
      bus.rd_data = pat(bus.rd_addr);
      if (rd_cnt < 64) rd_log[rd_cnt] = bus.rd_addr;
      rd_cnt = rd_cnt + 1;
      if (rd_cnt == err_read_at) bus.rd_err = 1'b1;
      if (seq_cnt < 128) seq_log[seq_cnt] = 1'b0;
      seq_cnt = seq_cnt + 1;
    end
    if (bus.wr_req === 1'b1) begin
      bus.wr_ack = 1'b1;
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = bus.wr_addr;
        wr_data_log[wr_cnt] = bus.wr_data;
      end
      wr_cnt = wr_cnt + 1;
      if (seq_cnt < 128) seq_log[seq_cnt] = 1'b1;
      seq_cnt = seq_cnt + 1;
    end
    if (bus.rd_req === 1'b1 && bus.wr_req === 1'b1) overlap = overlap + 1;
    if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    if (bus.error === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rd_cnt = 0; wr_cnt = 0; seq_cnt = 0; overlap = 0;
    done_cnt = 0; err_cnt = 0; err_read_at = 0;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                        input logic [1:0] w, input logic [2:0] b,
                        input logic si, input logic di);
    clear_logs();
    bus.src_addr      = s;
    bus.dst_addr      = d;
    bus.transfer_size = n;
    bus.data_width    = w;
    bus.burst_size    = b;
    bus.src_incr      = si;
    bus.dst_incr      = di;
    bus.start         = 1'b1;
    step();
    bus.start         = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy === 1'b1; i++) step();
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.transfer_size = '0;
    bus.burst_size = '0; bus.data_width = '0; bus.src_incr = 1'b0; bus.dst_incr = 1'b0;
    bus.rd_ack = 1'b0; bus.rd_err = 1'b0; bus.rd_data = '0;
    bus.wr_ack = 1'b0; bus.wr_err = 1'b0;
`ifdef DMA_ENGINE_ABORT_EN
    abort = 1'b0;
`endif
    clear_logs();
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("rst_done",   {31'd0, bus.done},   32'd0);
    chk("rst_error",  {31'd0, bus.error},  32'd0);
    chk("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    chk("rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
    chk("rst_remain", bus.remaining_bytes, 32'd0);
    chk("rst_src",    bus.cur_src_addr,    32'd0);
    chk("rst_dst",    bus.cur_dst_addr,    32'd0);

    // 64 bytes, 4-byte beats, 4-beat bursts
    launch(32'h1000, 32'h2000, 32'd64, 2'b10, 3'd2, 1'b1, 1'b1);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle(300);
    chk("t1_rd_cnt",  rd_cnt,   32'd16);
    chk("t1_wr_cnt",  wr_cnt,   32'd16);
    chk("t1_done",    done_cnt, 32'd1);
    chk("t1_err",     err_cnt,  32'd0);
    chk("t1_overlap", overlap,  32'd0);
    chk("t1_dst",     bus.cur_dst_addr,    32'h2040);
    chk("t1_src",     bus.cur_src_addr,    32'h1040);
    chk("t1_remain",  bus.remaining_bytes, 32'd0);
    for (int i = 0; i < 32; i++) chk("t1_seq", {31'd0, seq_log[i]}, 32'((i / 4) % 2));
    for (int i = 0; i < 16; i++) begin
      chk("t1_wr_addr", wr_addr_log[i], 32'h2000 + 32'(4 * i));
      chk("t1_wr_data", wr_data_log[i], pat(32'h1000 + 32'(4 * i)));
    end

    // size not a multiple of 4 -> fault straight from CHECK
    launch(32'h1000, 32'h2000, 32'd6, 2'b10, 3'd2, 1'b1, 1'b1);
    step();
    chk("t2_error_pulse", {31'd0, bus.error}, 32'd1);
    step();
    chk("t2_error_clear", {31'd0, bus.error}, 32'd0);
    chk("t2_busy",        {31'd0, bus.busy},  32'd0);
    chk("t2_rd_cnt",      rd_cnt,   32'd0);
    chk("t2_done",        done_cnt, 32'd0);

    // zero-length transfer
    launch(32'h1000, 32'h2000, 32'd0, 2'b10, 3'd2, 1'b1, 1'b1);
    step();
    chk("t3_done_pulse", {31'd0, bus.done}, 32'd1);
    step();
    chk("t3_done_clear", {31'd0, bus.done}, 32'd0);
    chk("t3_busy",       {31'd0, bus.busy}, 32'd0);
    chk("t3_bus",        rd_cnt + wr_cnt,   32'd0);

    // fixed source, burst capped by remaining beats
    launch(32'h3000, 32'h4000, 32'd16, 2'b10, 3'd7, 1'b0, 1'b1);
    wait_idle(100);
    chk("t4_rd_cnt", rd_cnt,   32'd4);
    chk("t4_done",   done_cnt, 32'd1);
    chk("t4_seq",    {28'd0, seq_log[0], seq_log[3], seq_log[4], seq_log[7]}, 32'b0011);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rd_addr", rd_log[i],      32'h3000);
      chk("t4_wr_addr", wr_addr_log[i], 32'h4000 + 32'(4 * i));
      chk("t4_wr_data", wr_data_log[i], pat(32'h3000));
    end
    chk("t4_src", bus.cur_src_addr, 32'h3000);

    // read error on third beat
    launch(32'h5000, 32'h6000, 32'd32, 2'b10, 3'd3, 1'b1, 1'b1);
    err_read_at = 3;
    wait_idle(100);
    chk("t5_err",    err_cnt,  32'd1);
    chk("t5_done",   done_cnt, 32'd0);
    chk("t5_wr_cnt", wr_cnt,   32'd0);
    chk("t5_remain", bus.remaining_bytes, 32'd32);
    chk("t5_src",    bus.cur_src_addr,    32'h5008);

    // reset in the middle of the second write beat
    launch(32'h5000, 32'h6000, 32'd16, 2'b10, 3'd2, 1'b1, 1'b1);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        if (bus.wr_req === 1'b1 && bus.wr_addr === 32'h6004) break;
        step();
      end
      chk("t6_reach_beat2", k < 100 ? 32'd1 : 32'd0, 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("t6_wr_req", {31'd0, bus.wr_req}, 32'd0);
    chk("t6_rd_req", {31'd0, bus.rd_req}, 32'd0);
    chk("t6_busy",   {31'd0, bus.busy},   32'd0);
    chk("t6_remain", bus.remaining_bytes, 32'd0);
    chk("t6_dst",    bus.cur_dst_addr,    32'd0);
    chk("t6_wr_cnt", wr_cnt, 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // address wrap past 0xFFFFFFFC after reset recovery
    launch(32'hFFFF_FFF8, 32'h300, 32'd16, 2'b10, 3'd1, 1'b1, 1'b1);
    wait_idle(100);
    chk("t7_done",  done_cnt, 32'd1);
    chk("t7_rd0",   rd_log[0], 32'hFFFF_FFF8);
    chk("t7_rd1",   rd_log[1], 32'hFFFF_FFFC);
    chk("t7_rd2",   rd_log[2], 32'h0000_0000);
    chk("t7_rd3",   rd_log[3], 32'h0000_0004);
    chk("t7_src",   bus.cur_src_addr, 32'h8);
    chk("t7_dst",   bus.cur_dst_addr, 32'h310);

    // 2-byte beats: data confined to low half-word
    launch(32'h100, 32'h202, 32'd4, 2'b01, 3'd0, 1'b1, 1'b1);
    wait_idle(100);
    chk("t8_done",  done_cnt, 32'd1);
    chk("t8_seq",   {28'd0, seq_log[0], seq_log[1], seq_log[2], seq_log[3]}, 32'b0101);
    chk("t8_data0", wr_data_log[0], pat(32'h100) & 32'h0000_FFFF);
    chk("t8_data1", wr_data_log[1], pat(32'h102) & 32'h0000_FFFF);
    chk("t8_addr1", wr_addr_log[1], 32'h204);
    chk("t8_dst",   bus.cur_dst_addr, 32'h206);

    // misaligned source for 2-byte beats
    launch(32'h101, 32'h200, 32'd4, 2'b01, 3'd0, 1'b1, 1'b1);
    wait_idle(20);
    chk("t9_err",    err_cnt, 32'd1);
    chk("t9_rd_cnt", rd_cnt,  32'd0);

    // reserved width encoding
    launch(32'h100, 32'h200, 32'd8, 2'b11, 3'd0, 1'b1, 1'b1);
    wait_idle(20);
    chk("t10_err",    err_cnt, 32'd1);
    chk("t10_rd_cnt", rd_cnt,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high:
  clk  in  1  clock; all state on rising edge
  rst  in  1  async active-high reset
REQ-002 SHALL have these transfer-request ports:
  start  in  1  one-cycle grant pulse; samples all params below
  src_addr  in  32  source byte address
  dst_addr  in  32  destination byte address
  transfer_size  in  32  byte count
  burst_size  in  3  log2 beats per burst
  data_width  in  2  00=1B, 01=2B, 10=4B, 11=reserved
  src_incr  in  1  increment source per beat
  dst_incr  in  1  increment destination per beat
REQ-003 SHALL have these read-port signals: rd_req out 1, rd_addr out 32, rd_size out 2, rd_ack in 1, rd_data in 32, rd_err in 1.
REQ-004 SHALL have these write-port signals: wr_req out 1, wr_addr out 32, wr_size out 2, wr_data out 32, wr_ack in 1, wr_err in 1.
REQ-005 SHALL have these status outputs: busy out 1, done out 1 (pulse), error out 1 (pulse), cur_src_addr out 32, cur_dst_addr out 32, remaining_bytes out 32.

Function
REQ-006 States SHALL be IDLE, CHECK, READ, WRITE, FINISH, FAULT; start SHALL be ignored outside IDLE.
REQ-007 IDLE+start SHALL latch all params into cur_src_addr, cur_dst_addr, remaining_bytes and width/incr registers, set busy, and enter CHECK next cycle.
REQ-008 CHECK: data_width=11, transfer_size not a multiple of bytes-per-beat (bpb), or src/dst misaligned to bpb SHALL go to FAULT; transfer_size=0 SHALL go to FINISH; otherwise SHALL go to READ.
REQ-009 Burst length SHALL be min(2^burst_size, 16, remaining_bytes/bpb) beats, computed on entry to READ.
REQ-010 READ: rd_req SHALL be held high with rd_addr/rd_size stable until rd_ack; each ack SHALL store rd_data in a 16x32 buffer; cur_src_addr SHALL advance by bpb if src_incr, else hold; after the last beat's ack the next state SHALL be WRITE.
REQ-011 WRITE: buffer beats SHALL be issued in order with the same hold-until-ack rule; each wr_ack SHALL advance cur_dst_addr by bpb if dst_incr and decrement remaining_bytes by bpb.
REQ-012 After the last write beat: remaining_bytes=0 SHALL go to FINISH, otherwise SHALL go to READ for the next burst.
REQ-013 rd_err or wr_err with ack SHALL go to FAULT; that beat SHALL NOT count, and addresses/remaining SHALL hold.
REQ-014 FINISH SHALL pulse done for exactly one cycle, clear busy, and return to IDLE; FAULT SHALL do the same with error instead of done.
REQ-015 rd_req and wr_req SHALL never be high together; a req SHALL be asserted no earlier than one cycle after the state entry that decides it.
REQ-016 Address arithmetic SHALL be 32-bit modulo (wrap 0xFFFFFFFC+4 -> 0x0); no 4KB boundary splitting.
REQ-017 Sub-word data SHALL travel in bits [8*bpb-1:0]; unused wr_data bits SHALL be zero.

Reset
REQ-018 rst SHALL force IDLE immediately, including mid-burst; all outputs, counters, and buffer pointers SHALL be 0, and rd_req/wr_req SHALL deassert asynchronously.

Configuration
REQ-019 With DMA_ENGINE_ABORT_EN defined, an input port abort (1 bit) SHALL exist; abort high in READ/WRITE SHALL take effect after the current beat's ack, enter FAULT, and pulse error; abort SHALL be ignored in IDLE.
REQ-020 Without DMA_ENGINE_ABORT_EN, no abort port SHALL exist and transfers SHALL run to completion or bus error.

Verification
REQ-021 src=0x1000, dst=0x2000, size=64, width=10, burst=2, both incr -> 4 bursts of 4 reads+4 writes; one done pulse; final cur_dst=0x2040, remaining=0.
REQ-022 size=6, width=10 -> CHECK to FAULT; error pulse; no rd_req.
REQ-023 size=0 -> done pulse two cycles after start; no bus activity.
REQ-024 src_incr=0, size=16, width=10, burst=7 -> one burst of 4 beats, all rd_addr=src; wr_addr steps by 4.
REQ-025 rd_err on the third read of a 32-byte transfer -> error pulse; remaining_bytes=32; wr_req never asserted.
REQ-026 rst asserted during WRITE beat 2 -> wr_req low same cycle; busy=0; next start runs normally.
